// File: rtl/pong_pkg.sv
// Shared definitions for the pong renderer: default geometry, colour
// selections and the constant-width helper used to size counters.
package pong_pkg;

  localparam int DEF_XW           = 10;
  localparam int DEF_CW           = 4;
  localparam int DEF_H_ACTIVE     = 640;
  localparam int DEF_V_ACTIVE     = 480;
  localparam int DEF_PAD_W        = 10;
  localparam int DEF_PAD_H        = 80;
  localparam int DEF_BALL_SZ      = 10;
  localparam int DEF_BORDER       = 8;
  localparam int DEF_FLASH_FRAMES = 15;

  // Named colours; the channel encoding for a given CW is built by the renderer.
  typedef enum logic [1:0] {
    COL_BLACK,
    COL_GREY,
    COL_WHITE,
    COL_RED
  } colour_e;

  // Bits needed to hold values 0..value-1 (minimum 1).
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((64'd1 << w) < 64'(value)) w++;
    return w;
  endfunction

endpackage

// File: rtl/pong_flash_timer.sv
// Frame-based ball flash timer: loads on a hit, counts frames down, and
// reports activity while the count is nonzero.
module pong_flash_timer
  import pong_pkg::*;
#(
  parameter int FLASH_FRAMES = DEF_FLASH_FRAMES
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic active
);

  localparam int             FW       = clog2(FLASH_FRAMES + 1);
  localparam logic [FW-1:0]  LOAD_VAL = FW'(FLASH_FRAMES);

  logic [FW-1:0] count_q, count_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LOAD_VAL;               // a new hit restarts the flash, even mid-count
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign active = (count_q != '0);

endmodule

// File: rtl/pong_sprite_renderer.sv
// Two-stage pong renderer: frame-latched positions, hit tests in stage 1,
// prioritised colour selection in stage 2.
module pong_sprite_renderer
  import pong_pkg::*;
#(
  parameter int XW           = DEF_XW,
  parameter int CW           = DEF_CW,
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int PAD_W        = DEF_PAD_W,
  parameter int PAD_H        = DEF_PAD_H,
  parameter int BALL_SZ      = DEF_BALL_SZ,
  parameter int BORDER       = DEF_BORDER,
  parameter int FLASH_FRAMES = DEF_FLASH_FRAMES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_pulse,
  input  logic          pxl_en,
  input  logic [XW-1:0] x,
  input  logic [XW-1:0] y,
  input  logic [XW-1:0] p1_y,
  input  logic [XW-1:0] p2_y,
  input  logic [XW-1:0] ball_x,
  input  logic [XW-1:0] ball_y,
  input  logic          hit_flash,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b,
  output logic          de
);

  // One extra bit so start+size never wraps.
  localparam int SW = XW + 1;
  typedef logic [SW-1:0] ext_t;

  localparam ext_t PAD_MAX   = SW'(V_ACTIVE - PAD_H);
  localparam ext_t BX_MAX    = SW'(H_ACTIVE - BALL_SZ);
  localparam ext_t BY_MAX    = SW'(V_ACTIVE - BALL_SZ);
  localparam ext_t PAD_W_E   = SW'(PAD_W);
  localparam ext_t PAD_H_E   = SW'(PAD_H);
  localparam ext_t BALL_E    = SW'(BALL_SZ);
  localparam ext_t RPAD_X_E  = SW'(H_ACTIVE - PAD_W);
  localparam ext_t BORDER_E  = SW'(BORDER);
  localparam ext_t BOT_WALL  = SW'(V_ACTIVE - BORDER);

  localparam logic [CW-1:0] CH_ONES = '1;
  localparam logic [CW-1:0] CH_MSB  = CW'(1) << (CW - 1);

  typedef struct packed {
    logic [XW-1:0] p1;
    logic [XW-1:0] p2;
    logic [XW-1:0] bx;
    logic [XW-1:0] by;
  } pos_t;

  typedef struct packed {
    logic en;
    logic ball;
    logic pad;
    logic wall;
  } hit_t;

  function automatic logic [XW-1:0] clamp(input logic [XW-1:0] v, input ext_t max);
    return ({1'b0, v} > max) ? max[XW-1:0] : v;
  endfunction

  pos_t          pos_q, pos_d;
  hit_t          hit_q, hit_d;
  logic [CW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic          de_q, de_d;
  logic          flashing;
  colour_e       colour;

  pong_flash_timer #(.FLASH_FRAMES(FLASH_FRAMES)) u_flash (
    .clk    (clk),
    .rst    (rst),
    .load   (hit_flash),
    .tick   (frame_pulse),
    .active (flashing)
  );

  always_comb begin
    pos_d = pos_q;
    if (frame_pulse) begin
      pos_d.p1 = clamp(p1_y,   PAD_MAX);
      pos_d.p2 = clamp(p2_y,   PAD_MAX);
      pos_d.bx = clamp(ball_x, BX_MAX);
      pos_d.by = clamp(ball_y, BY_MAX);
    end
  end

  // Stage 1 reads the registered shadows, so a frame_pulse only affects later pixels.
  always_comb begin
    ext_t xe, ye, p1e, p2e, bxe, bye;
    xe  = {1'b0, x};
    ye  = {1'b0, y};
    p1e = {1'b0, pos_q.p1};
    p2e = {1'b0, pos_q.p2};
    bxe = {1'b0, pos_q.bx};
    bye = {1'b0, pos_q.by};
    hit_d.en   = pxl_en;
    hit_d.pad  = ((xe < PAD_W_E)   && (ye >= p1e) && (ye < p1e + PAD_H_E)) ||
                 ((xe >= RPAD_X_E) && (ye >= p2e) && (ye < p2e + PAD_H_E));
    hit_d.ball = (xe >= bxe) && (xe < bxe + BALL_E) &&
                 (ye >= bye) && (ye < bye + BALL_E);
    hit_d.wall = (BORDER != 0) && ((ye < BORDER_E) || (ye >= BOT_WALL));
  end

  always_comb begin
    colour = COL_BLACK;
    if      (hit_q.ball) colour = flashing ? COL_RED : COL_WHITE;
    else if (hit_q.pad)  colour = COL_WHITE;
    else if (hit_q.wall) colour = COL_GREY;

    r_d  = '0;
    g_d  = '0;
    b_d  = '0;
    de_d = hit_q.en;
    if (hit_q.en) begin
      unique case (colour)
        COL_WHITE: begin r_d = CH_ONES; g_d = CH_ONES; b_d = CH_ONES; end
        COL_GREY:  begin r_d = CH_MSB;  g_d = CH_MSB;  b_d = CH_MSB;  end
        COL_RED:   r_d = CH_ONES;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= '0;
      hit_q <= '0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
      de_q  <= 1'b0;
    end else begin
      pos_q <= pos_d;
      hit_q <= hit_d;
      r_q   <= r_d;
      g_q   <= g_d;
      b_q   <= b_d;
      de_q  <= de_d;
    end
  end

  assign r  = r_q;
  assign g  = g_q;
  assign b  = b_q;
  assign de = de_q;

endmodule

// File: tb/tb_pong_sprite_renderer.sv
// Scoreboard bench for pong_sprite_renderer: directed pixels push expected
// colours with their due cycle; a monitor compares each one when it falls due.
module tb_pong_sprite_renderer;

  localparam logic [11:0] WHITE = 12'hFFF;
  localparam logic [11:0] GREY  = 12'h888;
  localparam logic [11:0] RED   = 12'hF00;
  localparam logic [11:0] BLACK = 12'h000;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_pulse, pxl_en, hit_flash;
  logic [9:0] x, y, p1_y, p2_y, ball_x, ball_y;
  logic [3:0] r, g, b;
  logic       de;

  typedef struct {
    int          due;
    logic        de;
    logic [11:0] rgb;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   cnt    = 0;

  pong_sprite_renderer dut (
    .clk         (clk),
    .rst         (rst),
    .frame_pulse (frame_pulse),
    .pxl_en      (pxl_en),
    .x           (x),
    .y           (y),
    .p1_y        (p1_y),
    .p2_y        (p2_y),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .hit_flash   (hit_flash),
    .r           (r),
    .g           (g),
    .b           (b),
    .de          (de)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare every expectation whose output cycle has arrived.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check(e.name, {19'd0, de, r, g, b}, {19'd0, e.de, e.rgb});
    end
  end

  task automatic drive(input logic en, input int xx, input int yy);
    @(negedge clk);
    pxl_en      = en;
    x           = 10'(xx);
    y           = 10'(yy);
    frame_pulse = 1'b0;
    hit_flash   = 1'b0;
  endtask

  task automatic pix(input int xx, input int yy, input logic [11:0] rgb, input string nm);
    exp_t e;
    drive(1'b1, xx, yy);
    e = '{due: cyc + 2, de: 1'b1, rgb: rgb, name: nm};
    sb.push_back(e);
  endtask

  task automatic pix_off(input int xx, input int yy, input string nm);
    exp_t e;
    drive(1'b0, xx, yy);
    e = '{due: cyc + 2, de: 1'b0, rgb: BLACK, name: nm};
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0);
  endtask

  // Frame strobe with no active pixel; optionally a simultaneous hit.
  task automatic frame(input int a, input int c, input int bxv, input int byv, input logic hf);
    @(negedge clk);
    p1_y        = 10'(a);
    p2_y        = 10'(c);
    ball_x      = 10'(bxv);
    ball_y      = 10'(byv);
    pxl_en      = 1'b0;
    frame_pulse = 1'b1;
    hit_flash   = hf;
    if (hf) cnt = 15;
    else if (cnt > 0) cnt--;
  endtask

  // Sample the ball once per frame, expecting red while the flash count is nonzero.
  task automatic flash_run(input string nm);
    for (int i = 0; i < 16; i++) begin
      pix(5, 5, (cnt != 0) ? RED : WHITE, nm);
      idle(2);
      frame(0, 0, 0, 0, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; frame_pulse = 1'b0; pxl_en = 1'b0; hit_flash = 1'b0;
    x = '0; y = '0; p1_y = '0; p2_y = '0; ball_x = '0; ball_y = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {28'd0, de, r}, 32'd0);
    check("reset_gb", {24'd0, g, b}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Frame strobe with a live pixel: that pixel still sees the old shadows.
    @(negedge clk);
    p1_y = 10'd100; p2_y = 10'd0; ball_x = 10'd300; ball_y = 10'd200;
    frame_pulse = 1'b1; hit_flash = 1'b0; pxl_en = 1'b1; x = 10'd5; y = 10'd100;
    sb.push_back('{due: cyc + 2, de: 1'b1, rgb: BLACK, name: "latch_same_cycle_old"});
    pix(5, 100, WHITE, "p1_top");
    pix(5, 179, WHITE, "p1_last_row");
    pix(5, 180, BLACK, "p1_past_end");
    pix(9, 100, WHITE, "p1_right_col");
    pix(10, 100, BLACK, "p1_past_width");
    pix(300, 3, GREY, "top_wall");
    pix(300, 472, GREY, "bottom_wall_start");
    pix(300, 471, BLACK, "above_bottom_wall");
    pix(305, 205, WHITE, "ball_mid");
    pix(310, 205, BLACK, "ball_past_right");
    pix_off(5, 100, "pxl_en_low");
    pix(635, 50, WHITE, "p2_at_zero");
    idle(3);

    // Right paddle clamp: 450 latches as 400.
    frame(100, 450, 300, 200, 1'b0);
    pix(635, 479, WHITE, "p2_clamp_bottom");
    pix(635, 400, WHITE, "p2_clamp_top");
    pix(635, 399, BLACK, "p2_above_clamp");
    pix(629, 420, BLACK, "p2_left_edge_out");
    pix(630, 420, WHITE, "p2_left_edge_in");
    idle(3);

    // Ball over left paddle, then flash sequences.
    frame(0, 0, 0, 0, 1'b0);
    pix(5, 5, WHITE, "ball_over_paddle");
    idle(2);
    @(negedge clk);
    pxl_en = 1'b0; frame_pulse = 1'b0; hit_flash = 1'b1;
    cnt = 15;
    flash_run("flash_after_hit");
    idle(2);
    frame(0, 0, 0, 0, 1'b1);
    flash_run("flash_hit_with_pulse");
    idle(3);

    // Reset mid-line with a full pipeline of white pixels.
    frame(100, 0, 300, 200, 1'b0);
    drive(1'b1, 5, 100);
    drive(1'b1, 5, 100);
    drive(1'b1, 5, 100);
    @(posedge clk);
    #2;
    check("pre_reset_white", {19'd0, de, r, g, b}, {19'd0, 1'b1, WHITE});
    rst = 1'b1; pxl_en = 1'b0;
    #1;
    check("reset_immediate", {19'd0, de, r, g, b}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pix_off(5, 100, "post_reset_no_stale");
    pix(5, 100, BLACK, "post_reset_shadow_cleared");
    frame(100, 0, 300, 200, 1'b0);
    pix(5, 100, WHITE, "post_reset_relatched");
    idle(4);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_sprite_renderer.md
PONG_SPRITE_RENDERER -- requirements
Module: pong_sprite_renderer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- XW, 10, pixel coordinate width.
- CW, 4, colour bits per channel.
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines.
- PAD_W, 10, paddle width.
- PAD_H, 80, paddle height.
- BALL_SZ, 10, ball edge length.
- BORDER, 8, top/bottom wall thickness; 0 disables walls.
- FLASH_FRAMES, 15, frames of ball flash after a hit.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, pixel clock.
- rst, in, 1, asynchronous active-high reset.
- frame_pulse, in, 1, one-cycle frame-start strobe.
- pxl_en, in, 1, active-video qualifier for x/y.
- x, in, XW, current pixel column.
- y, in, XW, current pixel row.
- p1_y, in, XW, left paddle top row.
- p2_y, in, XW, right paddle top row.
- ball_x, in, XW, ball left column.
- ball_y, in, XW, ball top row.
- hit_flash, in, 1, one-cycle strobe requesting a ball flash.
- r, out, CW, red output.
- g, out, CW, green output.
- b, out, CW, blue output.
- de, out, 1, pxl_en delayed to align with r/g/b.
REQ-003 Reset SHALL be rst, asynchronous, active-high; the clock SHALL be clk.

Function
REQ-004 Position inputs SHALL be sampled into shadow registers only on cycles with frame_pulse=1; the shadows hold between strobes.
REQ-005 Latched paddle rows SHALL be clamped to V_ACTIVE-PAD_H. Latched ball_x SHALL be clamped to H_ACTIVE-BALL_SZ, and ball_y to V_ACTIVE-BALL_SZ.
REQ-006 Hit tests SHALL be half-open [start, start+size). Sums SHALL be computed at XW+1 bits so that no wrap-around occurs.
REQ-007 Hit regions: left paddle x<PAD_W; right paddle x>=H_ACTIVE-PAD_W; ball; wall y<BORDER or y>=V_ACTIVE-BORDER.
REQ-008 Colour priority SHALL be, highest first: ball, paddles, wall, background.
REQ-009 Colours SHALL be:
- paddles white (all ones);
- wall grey (MSB only on each channel);
- background black;
- ball white, or red (r all ones, g=b=0) while flashing.
REQ-010 Pipeline: stage 1 registers the hit flags and pxl_en; stage 2 registers the colour and de. Latency from x/y/pxl_en to r/g/b/de SHALL be exactly 2 cycles.
REQ-011 When the delayed pxl_en is 0, r/g/b SHALL be 0 and de SHALL be 0.
REQ-012 The flash counter (width clog2(FLASH_FRAMES+1)):
- loads FLASH_FRAMES on hit_flash;
- decrements on each frame_pulse while nonzero;
- the ball is flashing while the counter is nonzero.
REQ-013 If hit_flash and frame_pulse occur in the same cycle, the load SHALL win. A hit during an active flash SHALL restart the count.
REQ-014 Position shadows latched at frame_pulse SHALL affect pixels entering stage 1 on the following cycle, never mid-line earlier.

Reset
REQ-015 On rst, all shadows, the flash counter, pipeline registers, r/g/b and de SHALL clear to 0 immediately. Output SHALL resume 2 cycles after the first valid pixel following release.
REQ-016 rst asserted mid-frame SHALL abort the pipeline with no stale pixel emitted after release.

Structure
REQ-017 Colour constants (white, grey, red, black), default geometry and the clog2 function SHALL live in shared package pong_pkg.
REQ-018 The flash counter SHALL be a sub-module, pong_flash_timer, with ports clk, rst, load, tick, active.

Verification
REQ-019 Bench SHALL cover:
- frame_pulse with p1_y=100; x=5, y=100 and x=5, y=179 -> white at de, 2 cycles later; x=5, y=180 -> black.
- p2_y=450 latched -> clamped to 400; x=635, y=479 -> white; y=399 -> black.
- ball (0,0) overlapping the left paddle at (5,5) -> ball colour. hit_flash -> red for exactly 15 frame_pulses, then white.
- hit_flash and frame_pulse in the same cycle -> counter = 15, not 14.
- pxl_en=0 at x=5, y=100 -> r=g=b=0, de=0 two cycles later. y=3 with BORDER=8 -> grey.
- rst pulse mid-line -> all outputs 0 immediately; first output 2 cycles after release is correct.
